// File: rtl/oversampling_period_meter.sv
// oversampling_period_meter: sample-resolution period/half-period meter with a no-signal timeout.
// Defining OVERSAMPLING_PERIOD_AVG_EN adds a 2^AVG_LOG2-period summing averager.
module oversampling_period_meter #(
    parameter int COUNTER_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AVG_LOG2       = 4,
    localparam int TS_W          = COUNTER_BITS + 6
) (
    input  logic                     CLK_PARALLEL,
    input  logic                     RESET,
    input  logic                     CE,
    input  logic                     CHANGED_FLAG,
    input  logic [5:0]               CHANGED_BIT,
    output logic                     PERIOD_VALID,
    output logic [TS_W-1:0]          PERIOD_OUT,
    output logic [TS_W-1:0]          HALF_PERIOD_OUT,
    output logic                     NO_SIGNAL,
    output logic                     AVG_VALID,
    output logic [TS_W+AVG_LOG2-1:0] AVG_SUM
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] TMO = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {EMPTY, ONE, TWO, RUN} state_t;

    state_t                  r_state, w_next;
    logic [COUNTER_BITS-1:0] r_cycle;
    logic [IDLE_W-1:0]       r_idle;
    logic [TS_W-1:0]         r_t1, r_t2, w_ts;
    logic                    w_chg, w_timeout;

    assign w_ts      = {r_cycle, CHANGED_BIT};
    assign w_chg     = CE & CHANGED_FLAG;
    // A change in the cycle the idle count would reach the limit takes priority.
    assign w_timeout = CE & ~CHANGED_FLAG & (r_idle >= TMO - IDLE_W'(1));

    always_comb begin
        w_next = w_chg ? ((r_state == RUN) ? RUN : state_t'(r_state + 2'd1))
               : w_timeout ? EMPTY : r_state;
    end

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            r_state         <= EMPTY;
            r_cycle         <= '0;
            r_idle          <= '0;
            r_t1            <= '0;
            r_t2            <= '0;
            PERIOD_VALID    <= 1'b0;
            PERIOD_OUT      <= '0;
            HALF_PERIOD_OUT <= '0;
            NO_SIGNAL       <= 1'b1;
        end else begin
            PERIOD_VALID <= w_chg & (r_state == TWO || r_state == RUN);
            if (CE) begin
                r_cycle   <= r_cycle + 1'b1;
                r_state   <= w_next;
                NO_SIGNAL <= w_next != RUN;
                r_idle    <= w_chg ? '0 : w_timeout ? TMO : r_idle + 1'b1;
                if (w_chg) begin
                    r_t2 <= r_t1;
                    r_t1 <= w_ts;
                    if (r_state == TWO || r_state == RUN) begin
                        PERIOD_OUT      <= w_ts - r_t2;
                        HALF_PERIOD_OUT <= w_ts - r_t1;
                    end
                end
            end
        end
    end

`ifdef OVERSAMPLING_PERIOD_AVG_EN
    logic [AVG_LOG2-1:0]      r_cnt;
    logic [TS_W+AVG_LOG2-1:0] r_acc, w_sum;

    assign w_sum = r_acc + (TS_W+AVG_LOG2)'(PERIOD_OUT);

    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            AVG_VALID <= 1'b0;
            AVG_SUM   <= '0;
        end else begin
            AVG_VALID <= CE & PERIOD_VALID & (&r_cnt);
            if (w_timeout) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (CE && PERIOD_VALID) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= (&r_cnt) ? '0 : w_sum;
                if (&r_cnt) AVG_SUM <= w_sum;
            end
        end
    end
`else
    assign AVG_VALID = 1'b0;
    assign AVG_SUM   = '0;
`endif
endmodule

// File: tb/tb_oversampling_period_meter.sv
// tb_oversampling_period_meter: randomized and directed checks against a timestamp-queue model.
module tb_oversampling_period_meter;
    localparam int CB   = 8;
    localparam int TO   = 100;
    localparam int AL   = 2;
    localparam int TS_W = CB + 6;
    localparam int AW   = TS_W + AL;

    logic            clk = 1'b0;
    logic            rst, ce, flag;
    logic [5:0]      cbit;
    logic            pv, ns, av;
    logic [TS_W-1:0] po, hp;
    logic [AW-1:0]   as_o;

    always #5 clk = ~clk;

    oversampling_period_meter #(.COUNTER_BITS(CB), .TIMEOUT_CYCLES(TO), .AVG_LOG2(AL)) dut (
        .CLK_PARALLEL(clk), .RESET(rst), .CE(ce), .CHANGED_FLAG(flag), .CHANGED_BIT(cbit),
        .PERIOD_VALID(pv), .PERIOD_OUT(po), .HALF_PERIOD_OUT(hp), .NO_SIGNAL(ns),
        .AVG_VALID(av), .AVG_SUM(as_o)
    );

    int              checks = 0;
    int              errors = 0;
    int              mcyc = 0;
    int              last = 0;
    longint          q[$];
    longint          s = 0;
    longint          acc = 0;
    int              cnt = 0;
    bit              e_pv, e_ns, e_av;
    logic [TS_W-1:0] e_po, e_hp;
    logic [AW-1:0]   e_as;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d (cycle %0d)", tag, act, exp, mcyc);
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare.
    task automatic cyc(input bit r, input bit f, input int b, input bit c);
        longint ts;
        rst = r; flag = f; cbit = b[5:0]; ce = c;
        @(posedge clk);
        if (r) begin
            q.delete(); mcyc = 0; last = 0; acc = 0; cnt = 0;
            e_pv = 0; e_po = '0; e_hp = '0; e_ns = 1; e_av = 0; e_as = '0;
        end else if (c) begin
            e_av = 0;
            if (e_pv) begin
                acc += e_po;
                cnt++;
                if (cnt == (1 << AL)) begin e_av = 1; e_as = AW'(acc); acc = 0; cnt = 0; end
            end
            e_pv = 0;
            if (f) begin
                ts = longint'(mcyc) * 64 + b;
                if (mcyc - last > TO) begin q.delete(); acc = 0; cnt = 0; end
                q.push_back(ts);
                if (q.size() > 3) void'(q.pop_front());
                if (q.size() == 3) begin
                    e_pv = 1;
                    e_po = TS_W'(ts - q[0]);
                    e_hp = TS_W'(ts - q[1]);
                end
                last = mcyc;
            end
            e_ns = !(q.size() == 3 && mcyc - last < TO);
            mcyc++;
        end else begin
            e_pv = 0; e_av = 0;
        end
        #1;
        chk("period_valid", pv, e_pv);
        chk("period_out", po, e_po);
        chk("half_period_out", hp, e_hp);
        chk("no_signal", ns, e_ns);
`ifdef OVERSAMPLING_PERIOD_AVG_EN
        chk("avg_valid", av, e_av);
        chk("avg_sum", as_o, e_as);
`else
        chk("avg_valid_tied", av, 0);
        chk("avg_sum_tied", as_o, 0);
`endif
    endtask

    // Advance the wave by `half` samples and report the change; optional frozen gap before it.
    task automatic chg(input int half, input bit gaps);
        int target, idle;
        s += half;
        target = int'(s >> 6);
        idle = 0;
        while (mcyc < target) begin
            cyc(0, 0, $urandom_range(63), 1);
            idle++;
        end
        if (gaps && idle > 0 && $urandom_range(1) == 1)
            repeat (10) cyc(0, $urandom_range(1), $urandom_range(63), 0);
        cyc(0, 1, int'(s % 64), 1);
    endtask

    task automatic restart_wave();
        s = longint'(mcyc) * 64;
    endtask

    initial begin
        repeat (2) cyc(1, 0, 0, 1);
        chk("reset_no_signal", ns, 1);
        chk("reset_period_out", po, 0);
        // 50% square, period 1000: ts 100, 600, 1100, 1600.
        restart_wave();
        chg(100, 0);
        chg(500, 0);
        chk("sq_no_signal_before", ns, 1);
        chg(500, 0);
        chk("sq_first_period", po, 1000);
        chk("sq_first_half", hp, 500);
        chk("sq_first_ns", ns, 0);
        for (int i = 0; i < 5; i++) chg(500, 0);
        // 30% duty.
        for (int i = 0; i < 8; i++) chg((i % 2 == 0) ? 300 : 700, 0);
        // 3000-sample period across several counter wraps.
        for (int i = 0; i < 24; i++) chg(1500, 0);
        // Change exactly at the timeout boundary survives.
        repeat (TO - 1) cyc(0, 0, 0, 1);
        cyc(0, 1, 7, 1);
        chk("coincident_ns", ns, 0);
        restart_wave();
        for (int i = 0; i < 3; i++) chg(400, 0);
        // One cycle too late: measurement restarts.
        repeat (TO) cyc(0, 0, 0, 1);
        cyc(0, 1, 9, 1);
        chk("late_ns", ns, 1);
        restart_wave();
        chg(300, 0);
        chg(300, 0);
        chk("late_third_valid", pv, 1);
        // Long silence, then resume.
        repeat (TO + 5) cyc(0, 0, 0, 1);
        restart_wave();
        for (int i = 0; i < 6; i++) chg(800, 0);
        // Frozen CE gaps between changes.
        for (int i = 0; i < 12; i++) chg($urandom_range(200, 2000), 1);
        // Averager: periods 1000..1003 from a clean reset.
        cyc(1, 0, 0, 1);
        restart_wave();
        chg(100, 0);
        chg(500, 0);
        chg(500, 0);
        chg(501, 0);
        chg(501, 0);
        chg(502, 0);
`ifdef OVERSAMPLING_PERIOD_AVG_EN
        cyc(0, 0, 0, 1);
        chk("avg_4006", as_o, 4006);
`endif
        // Reset mid-batch, then new batch.
        for (int i = 0; i < 2; i++) chg(700, 0);
        cyc(1, 1, 3, 1);
        restart_wave();
        for (int i = 0; i < 12; i++) chg($urandom_range(64, 3000), 0);
        // Randomized waves with gaps, silences and resets.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(9))
                0: begin repeat ($urandom_range(TO - 2, TO + 2)) cyc(0, 0, 0, 1); restart_wave(); end
                1: begin cyc(1, $urandom_range(1), 0, 1); restart_wave(); end
                default: chg($urandom_range(64, 3000), 1);
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
